// File: rtl/perf_counter_bank_pkg.sv
// Shared constants and types for the performance-counter bank.
// Register map offsets are relative to the 512-byte window base.
package perf_pkg;

  localparam int         CNT_STRIDE = 8;
  localparam logic [8:0] CTRL_OFF   = 9'h100;
  localparam logic [8:0] OVF_OFF    = 9'h104;

  typedef struct packed {
    logic freeze;
    logic enable;
  } perf_ctrl_t;

  localparam perf_ctrl_t CTRL_RESET = '{freeze: 1'b0, enable: 1'b1};

endpackage

// File: rtl/perf_counter_bank_if.sv
// CPU-side data-memory port plus the downstream (forwarded) port.
// slave = the counter bank, master = the CPU/memory side driving it.
interface perf_counter_bank_if;

  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        fwd_read;
  logic        fwd_write;
  logic [31:0] fwd_rdata;
  logic        fwd_resp;

  modport slave (
    input  mem_addr, mem_read, mem_write, mem_wdata, fwd_rdata, fwd_resp,
    output mem_rdata, mem_resp, fwd_read, fwd_write
  );

  modport master (
    output mem_addr, mem_read, mem_write, mem_wdata, fwd_rdata, fwd_resp,
    input  mem_rdata, mem_resp, fwd_read, fwd_write
  );

endinterface

// File: rtl/perf_counter_bank_cell.sv
// One event counter with clear, saturate-or-wrap overflow and an overflow strobe.
module perf_counter_cell #(
  parameter int CNT_W    = 48,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf_pulse
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             at_max;

  assign at_max    = &cnt_q;
  // A clear in the same cycle swallows the event, so it cannot overflow either.
  assign ovf_pulse = inc & ~clr & at_max;
  assign cnt       = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      if (at_max) cnt_d = SATURATE ? cnt_q : '0;
      else        cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/perf_counter_bank.sv
// Memory-mapped performance-counter bank on the CPU data path; misses pass
// straight through to the downstream port.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int          NUM_CNT   = 16,
  parameter int          CNT_W     = 48,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter bit          SATURATE  = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  perf_counter_bank_if.slave  bus,
  input  logic [NUM_CNT-1:0]  evt
);

  logic               hit;
  logic               accept;
  logic               rd_acc;
  logic               wr_acc;
  logic [8:0]         off;
  perf_ctrl_t         ctrl_q;
  logic [NUM_CNT-1:0] ovf_q;
  logic [NUM_CNT-1:0] ovf_pulse;
  logic [NUM_CNT-1:0] ovf_clr;
  logic [NUM_CNT-1:0] inc;
  logic [NUM_CNT-1:0] clr;
  logic [NUM_CNT-1:0] lo_sel;
  logic [NUM_CNT-1:0] hi_sel;
  logic [CNT_W-1:0]   cnt [NUM_CNT];
  logic               ack_q;
  logic [31:0]        rdata_q;
  logic [31:0]        rdata_d;
  logic [31:0]        hi_shadow;
  logic [31:0]        shadow_d;
  logic               unused_wdata;

  // Bits above 31 zero-extended; yields 0 when CNT_W is 32.
  function automatic logic [31:0] hi_word(input logic [CNT_W-1:0] v);
    logic [63:0] e;
    e = 64'(v);
    return e[63:32];
  endfunction

  assign hit    = (bus.mem_addr[31:9] == BASE_ADDR[31:9]);
  assign off    = bus.mem_addr[8:0];
  assign accept = hit & (bus.mem_read | bus.mem_write) & ~ack_q;
  assign rd_acc = accept & bus.mem_read;
  assign wr_acc = accept & ~bus.mem_read & bus.mem_write;

  always_comb begin
    lo_sel = '0;
    hi_sel = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      lo_sel[i] = (off == 9'(i * CNT_STRIDE));
      hi_sel[i] = (off == 9'(i * CNT_STRIDE + 4));
    end
  end

  assign inc     = evt & {NUM_CNT{ctrl_q.enable & ~ctrl_q.freeze}};
  assign clr     = {NUM_CNT{wr_acc}} & (lo_sel | hi_sel);
  assign ovf_clr = (wr_acc && off == OVF_OFF) ? bus.mem_wdata[NUM_CNT-1:0] : '0;

  always_comb begin
    rdata_d  = '0;
    shadow_d = hi_shadow;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (lo_sel[i]) begin
        rdata_d  = cnt[i][31:0];
        shadow_d = hi_word(cnt[i]);
      end
      if (hi_sel[i]) rdata_d = hi_shadow;
    end
    if (off == CTRL_OFF) rdata_d = 32'(ctrl_q);
    if (off == OVF_OFF)  rdata_d = 32'(ovf_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      hi_shadow <= '0;
      ctrl_q    <= CTRL_RESET;
      ovf_q     <= '0;
    end else begin
      ack_q <= accept;
      if (accept)                 rdata_q   <= rd_acc ? rdata_d : '0;
      if (rd_acc && (|lo_sel))   hi_shadow <= shadow_d;
      if (wr_acc && off == CTRL_OFF) ctrl_q <= perf_ctrl_t'(bus.mem_wdata[1:0]);
      // A fresh overflow beats a write-1-to-clear of the same bit.
      ovf_q <= (ovf_q & ~ovf_clr) | ovf_pulse;
    end
  end

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cell
    perf_counter_cell #(
      .CNT_W    (CNT_W),
      .SATURATE (SATURATE)
    ) u_cell (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc       (inc[g]),
      .clr       (clr[g]),
      .cnt       (cnt[g]),
      .ovf_pulse (ovf_pulse[g])
    );
  end

  assign bus.fwd_read  = bus.mem_read  & ~hit;
  assign bus.fwd_write = bus.mem_write & ~hit;
  assign bus.mem_resp  = rst_n & (hit ? ack_q : bus.fwd_resp);
  assign bus.mem_rdata = hit ? (ack_q ? rdata_q : '0) : bus.fwd_rdata;

  assign unused_wdata = ^bus.mem_wdata;

endmodule
